// File: rtl/ula_scheduler.sv
// Round-robin scheduler that shares one ula between NREQ requesters.
// It latches the winner's operands onto the ula inputs and waits ULA_LAT cycles for
// the registered result. It then returns that result with a one-cycle done pulse.
module ula_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ULA_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] sel_in,
  input  logic [2*NREQ-1:0] a_in,
  input  logic [NREQ-1:0]   b_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [2:0]        resultado,
  output logic              busy,
  output logic [15:0]       op_count,
  output logic [3:0]        ula_sel,
  output logic [1:0]        ula_a,
  output logic              ula_b,
  input  logic [2:0]        ula_saida
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(ULA_LAT + 1);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [2:0]        res_q, res_d;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        a_q, a_d;
  logic              b_q, b_d;

  logic              pick_valid;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW:0]     cand;

  // Circular search: first requester at or after the priority pointer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NREQ)) cand = cand - (PtrW+1)'(NREQ);
      if (!pick_valid && req[cand[PtrW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PtrW-1:0];
      end
    end
  end

  // Next-state logic for the FSM and every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wait_d  = wait_q;
    grant_d = grant_q;
    done_d  = done_q;
    res_d   = res_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          win_d           = pick_idx;
          sel_d           = sel_in[{pick_idx, 2'b00} +: 4];
          a_d             = a_in[{pick_idx, 1'b0} +: 2];
          b_d             = b_in[pick_idx];
          grant_d         = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          wait_d          = '0;
          state_d         = StExec;
        end
      end
      StExec: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == CntW'(ULA_LAT - 1)) state_d = StCapt;
      end
      StCapt: begin
        // ula has no reset, so its output is only trusted here.
        res_d         = ula_saida;
        done_d        = '0;
        done_d[win_q] = 1'b1;
        cnt_d         = cnt_q + 16'd1;
        state_d       = StResp;
      end
      StResp: begin
        done_d  = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; a reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      wait_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wait_q  <= wait_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign resultado = res_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;
  assign ula_sel   = sel_q;
  assign ula_a     = a_q;
  assign ula_b     = b_q;

endmodule

// File: tb/tb_ula_scheduler.sv
// Self-checking bench for ula_scheduler with a behavioural registered ula and a scoreboard
// of expected completions in service order.
module tb_ula_scheduler;

  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] sel_in;
  logic [2*NREQ-1:0] a_in;
  logic [NREQ-1:0]   b_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [2:0]        resultado;
  logic              busy;
  logic [15:0]       op_count;
  logic [3:0]        ula_sel;
  logic [1:0]        ula_a;
  logic              ula_b;
  logic [2:0]        ula_saida;

  ula_scheduler #(.NREQ(NREQ), .ULA_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel_in    (sel_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .done      (done),
    .resultado (resultado),
    .busy      (busy),
    .op_count  (op_count),
    .ula_sel   (ula_sel),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_saida (ula_saida)
  );

  always #5 clk = ~clk;

  // Stand-in ula: a few ops, result registered on posedge (one cycle latency).
  function automatic logic [2:0] ula_f(input logic [3:0] s, input logic [1:0] a, input logic b);
    case (s)
      4'h0:    return {1'b0, a} + {2'b00, b};
      4'h1:    return {1'b0, a} - {2'b00, b};
      4'h2:    return {1'b0, a & {2{b}}};
      4'h3:    return {1'b0, a | {2{b}}};
      4'hF:    return {1'b0, a} * {2'b00, b};
      default: return {b, a};
    endcase
  endfunction

  always @(posedge clk) ula_saida <= ula_f(ula_sel, ula_a, ula_b);

  typedef struct packed {
    logic [1:0] k;
    logic [2:0] res;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_done  = 0;
  int          last_done_cyc = 0;
  int          gap     = 0;
  logic        drop_en = 1'b1;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [3:0] s, input logic [1:0] a, input logic b);
    sel_in[4*k +: 4] = s;
    a_in[2*k +: 2]   = a;
    b_in[k]          = b;
  endtask

  // Raise a request and record the completion expected for it.
  task automatic drive_req(input int k, input logic [3:0] s, input logic [1:0] a, input logic b);
    exp_t e;
    set_ops(k, s, a, b);
    e.k   = 2'(k);
    e.res = ula_f(s, a, b);
    sb.push_back(e);
    req[k] = 1'b1;
  endtask

  // One clock; samples outputs at negedge and scores any done pulse.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (done !== '0) begin
      check_eq("done_onehot", $countones(done), 1);
      check_eq("grant_in_done", grant, done);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'd1;
        check_eq("done_who", done, 4'b0001 << e.k);
        check_eq("resultado", resultado, e.res);
        check_eq("op_count", op_count, exp_cnt);
      end
      n_done++;
      gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      if (drop_en) req = req & ~done;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      tick();
      n++;
    end
    if (n_done < target) check_eq("done_timeout", n_done, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    sb.delete();
  endtask

  initial begin
    int c0;
    rst    = 1'b1;
    req    = '0;
    sel_in = '0;
    a_in   = '0;
    b_in   = '0;
    do_reset();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_resultado", resultado, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_ula", {ula_sel, ula_a, ula_b}, 0);

    // 1: single request, latency and held operands.
    c0 = cyc;
    drive_req(0, 4'h0, 2'b11, 1'b1);
    tick();
    check_eq("t1_grant", grant, 4'b0001);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ula", {ula_sel, ula_a, ula_b}, {4'h0, 2'b11, 1'b1});
    wait_done(1, 10);
    check_eq("t1_latency", last_done_cyc - c0, 3);
    check_eq("t1_res", resultado, 3'b100);
    tick();
    check_eq("t1_after", {grant, done, busy}, 0);

    // 2: two simultaneous requests from pointer 0.
    do_reset();
    drive_req(1, 4'h2, 2'b11, 1'b1);
    drive_req(2, 4'h3, 2'b10, 1'b1);
    wait_done(n_done + 2, 20);

    // 3: all requesters held high; order 0,1,2,3,0 at a 4-cycle spacing.
    do_reset();
    drop_en = 1'b0;
    set_ops(0, 4'h0, 2'b10, 1'b1);
    set_ops(1, 4'h1, 2'b11, 1'b1);
    set_ops(2, 4'h5, 2'b01, 1'b1);
    set_ops(3, 4'hF, 2'b11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_req(i % 4, sel_in[4*(i%4) +: 4], a_in[2*(i%4) +: 2], b_in[i%4]);
    end
    wait_done(n_done + 1, 10);
    for (int i = 0; i < 4; i++) begin
      wait_done(n_done + 1, 10);
      check_eq("t3_gap", gap, 4);
    end
    req = '0;
    drop_en = 1'b1;
    tick();
    tick();
    check_eq("t3_idle", busy, 0);

    // 4: req dropped and operands changed right after grant.
    drive_req(3, 4'hF, 2'b01, 1'b1);
    tick();
    check_eq("t4_grant", grant, 4'b1000);
    tick();
    req[3] = 1'b0;
    set_ops(3, 4'h0, 2'b11, 1'b0);
    wait_done(n_done + 1, 10);
    check_eq("t4_res", resultado, 3'b001);
    check_eq("t4_ula_held", ula_sel, 4'hF);

    // 5: move the pointer to 2, then reset during EXEC.
    drive_req(1, 4'h0, 2'b01, 1'b1);
    wait_done(n_done + 1, 10);
    tick();
    set_ops(2, 4'h0, 2'b10, 1'b0);
    req[2] = 1'b1;
    tick();
    check_eq("t5_busy", busy, 1);
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    check_eq("t5_rst_out", {grant, done, busy, resultado}, 0);
    check_eq("t5_rst_cnt", op_count, 0);
    check_eq("t5_rst_ula", {ula_sel, ula_a, ula_b}, 0);
    tick();
    tick();
    check_eq("t5_no_done", done, 0);
    drive_req(0, 4'h1, 2'b10, 1'b1);
    drive_req(3, 4'h4, 2'b10, 1'b1);
    tick();
    check_eq("t5_ptr0", grant, 4'b0001);
    wait_done(n_done + 2, 20);

    // 6: op_count wraps from 0xFFFF.
    tick();
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    check_eq("t6_preload", op_count, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    drive_req(2, 4'h0, 2'b01, 1'b0);
    wait_done(n_done + 1, 10);
    check_eq("t6_wrap", op_count, 16'h0000);
    tick();

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
